digit_serial_adder: RTL and testbench
=====================================

# digit_serial_adder

Parametrised, handshaked successor to the flat 4-bit ripple adder benchmark. It computes `a + b + cin` or `a - b - borrow` on W-bit operands, D bits per clock, so one netlist trades area for latency across the adder benchmark family. It sits between a valid/ready operand source and a valid/ready result sink. It is the sequential reference target for CGP evolution of arithmetic datapaths.

## Interface
- `W`, 4: operand/result width in bits.
- `D`, 1: digit width processed per cycle. Legal only when 1 ≤ D ≤ W and W % D == 0; any other value is an elaboration error.
- `clk` input 1: single clock; all state changes on its rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `in_valid` input 1: operand set offered.
- `in_ready` output 1: block can accept operands.
- `in_a` input W: operand A.
- `in_b` input W: operand B.
- `in_cin` input 1: carry-in for add; borrow-in for subtract.
- `in_sub` input 1: 0 = add, 1 = subtract.
- `out_valid` output 1: result available.
- `out_ready` input 1: sink accepts result.
- `out_sum` output W: result bits.
- `out_cout` output 1: carry out of the MSB (for subtract, 1 = no borrow).
- `out_ovf` output 1: two's-complement overflow.

## Operation
- FSM states are IDLE, RUN and DONE. N = W/D digits.
- IDLE:
  - `in_ready` = 1.
  - On `in_valid & in_ready`, latch A into `a_sh` and B or ~B (if `in_sub`) into `b_sh`.
  - Carry register ← `in_cin ^ in_sub`.
  - Digit counter ← 0; clear the result register; go to RUN.
- RUN, each cycle:
  - Add the low D bits of `a_sh`/`b_sh` with the carry register.
  - Shift both operands right by D.
  - Shift the D-bit digit sum into the result register from the MSB side.
  - Update the carry register; increment the counter.
- RUN, on the digit with counter == N-1:
  - Also capture the carry into bit W-1 and the carry out of bit W-1.
  - Go to DONE.
- DONE:
  - `out_valid` = 1; `out_sum`, `out_cout` and `out_ovf` hold steady.
  - On `out_valid & out_ready`, go to IDLE.
- Result definitions:
  - `out_cout` = carry out of bit W-1.
  - `out_ovf` = carry-in to bit W-1 XOR carry-out of bit W-1.
  - Add: `{out_cout, out_sum}` = A + B + cin (W+1 bits).
  - Subtract: `out_sum` = (A - B - cin) mod 2^W.
- Inputs are sampled only on the accept edge; operand changes at any other time are ignored.
- `in_ready` = 0 in RUN and DONE. `in_valid` in those states is ignored and does not queue.

## Timing
- Accept edge T0. RUN occupies edges T1..TN. `out_valid` rises after edge TN.
  - Latency is N cycles from accept to `out_valid`.
  - D == W gives a single RUN cycle.
- Result consumed at edge TR: `out_valid` falls and `in_ready` rises after TR.
  - There is no same-edge re-accept.
  - Peak throughput is one operation per N+2 cycles.
- Outputs are registered or derived directly from state. No combinational path from inputs to outputs.
- `out_ready` held low: the block stays in DONE indefinitely with all outputs bit-stable.
- Reset values (after any edge with `rst` = 1):
  - State IDLE.
  - `out_valid` = 0, `out_sum` = 0, `out_cout` = 0, `out_ovf` = 0.
  - `in_ready` = 0 while `rst` is high, 1 on the first cycle after `rst` falls.
- Reset in RUN or DONE abandons the operation. No `out_valid` is produced for it.
- `rst` with `in_valid` on the same edge: reset wins and the operands are dropped.

## Structure
- Shared package `adder_pkg`:
  - FSM state enum (`ST_IDLE`, `ST_RUN`, `ST_DONE`).
  - Function `digits(W, D)` returning N.
  - Elaboration-check macro for W/D legality, shared with future adder variants.
- Sub-module `digit_adder`:
  - Combinational D-bit ripple adder, parameter D.
  - Ports `a[D]`, `b[D]`, `cin` → `sum[D]`, `cout`, `c_msb` (carry into its top bit).
  - Reused by later multiplier and accumulator blocks.
- Top level holds the FSM, shift registers, counter (width clog2(N)+1), carry register and output registers.

## Test plan
- W=4, D=1, add, A=0xF, B=0x1, cin=0 → after 4 cycles: `out_sum`=0x0, `out_cout`=1, `out_ovf`=0.
- W=4, D=1, sub, A=0x3, B=0x5, cin=0 → `out_sum`=0xE, `out_cout`=0, `out_ovf`=0.
- W=4, D=1, add, A=0x7, B=0x1 → `out_sum`=0x8, `out_cout`=0, `out_ovf`=1.
- W=8, D=4, add, A=0xFF, B=0xFF, cin=1:
  - `out_valid` asserts 2 cycles after accept.
  - `out_sum`=0xFF, `out_cout`=1, `out_ovf`=0.
- Backpressure:
  - Hold `out_ready`=0 for 5 cycles in DONE while toggling `in_valid` and operands → outputs unchanged, `in_ready`=0.
  - Then `out_ready`=1 → `in_ready`=1 the next cycle.
- Reset at T2 of a W=4, D=1 op:
  - `out_valid` never asserts and all outputs read 0.
  - A new op A=0x2, B=0x3 afterwards yields 0x5.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared definitions for the adder family: FSM state encoding, digit count helper
// and the W/D legality check used by every digit-serial variant.
`ifndef ADDER_PKG_SV
`define ADDER_PKG_SV

// Expands to a generate-time error when D does not evenly split W into digits.
`define ADDER_CHECK_WD(W_, D_) \
    if ((D_) < 1 || (D_) > (W_) || ((W_) % (D_)) != 0) begin : g_illegal_wd \
        $error("adder: illegal W/D combination"); \
    end

package adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic int digits(input int w, input int d);
        return (d > 0) ? (w / d) : 1;
    endfunction

endpackage

`endif

// File: rtl/digit_adder.sv
// Combinational D-bit adder slice; also exposes the carry into its top bit so
// callers can derive two's-complement overflow.
module digit_adder #(
    parameter int D = 1
) (
    input  logic [D-1:0] a,
    input  logic [D-1:0] b,
    input  logic         cin,
    output logic [D-1:0] sum,
    output logic         cout,
    output logic         c_msb
);
    logic [D:0] tot;

    assign tot   = {1'b0, a} + {1'b0, b} + {{D{1'b0}}, cin};
    assign sum   = tot[D-1:0];
    assign cout  = tot[D];
    // Top sum bit is a^b^carry_in, so the carry into it falls out by XOR.
    assign c_msb = a[D-1] ^ b[D-1] ^ sum[D-1];
endmodule

// File: rtl/digit_serial_adder.sv
// Digit-serial add/subtract: W-bit operands consumed D bits per clock behind
// valid/ready handshakes on both operand and result sides.
module digit_serial_adder
    import adder_pkg::*;
#(
    parameter int W = 4,
    parameter int D = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    input  logic         in_cin,
    input  logic         in_sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_sum,
    output logic         out_cout,
    output logic         out_ovf
);
    `ADDER_CHECK_WD(W, D)

    localparam int N  = digits(W, D);
    localparam int CW = $clog2(N) + 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_e        state_q, state_d;
    logic          in_ready_q, in_ready_d;
    logic [W-1:0]  a_sh_q, a_sh_d;
    logic [W-1:0]  b_sh_q, b_sh_d;
    logic          carry_q, carry_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  res_q, res_d;
    logic          cout_q, cout_d;
    logic          ovf_q, ovf_d;

    logic [D-1:0]  dig_sum;
    logic          dig_cout;
    logic          dig_cmsb;
    logic [W+D-1:0] res_cat;

    digit_adder #(.D(D)) u_digit (
        .a     (a_sh_q[D-1:0]),
        .b     (b_sh_q[D-1:0]),
        .cin   (carry_q),
        .sum   (dig_sum),
        .cout  (dig_cout),
        .c_msb (dig_cmsb)
    );

    // New digit enters at the MSB end so the LSB digit lands at bit 0 after N steps.
    assign res_cat = {dig_sum, res_q};

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready_q) begin
                    a_sh_d  = in_a;
                    b_sh_d  = in_sub ? ~in_b : in_b;
                    carry_d = in_cin ^ in_sub;
                    cnt_d   = '0;
                    res_d   = '0;
                    cout_d  = 1'b0;
                    ovf_d   = 1'b0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                a_sh_d  = a_sh_q >> D;
                b_sh_d  = b_sh_q >> D;
                res_d   = res_cat[W+D-1:D];
                carry_d = dig_cout;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    cout_d  = dig_cout;
                    ovf_d   = dig_cmsb ^ dig_cout;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        // Registered so in_ready carries no path from rst or the handshake inputs.
        in_ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            in_ready_q <= 1'b0;
            res_q      <= '0;
            cout_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
            res_q      <= res_d;
            cout_q     <= cout_d;
            ovf_q      <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        a_sh_q  <= a_sh_d;
        b_sh_q  <= b_sh_d;
        carry_q <= carry_d;
        cnt_q   <= cnt_d;
    end

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q == ST_DONE);
    assign out_sum   = res_q;
    assign out_cout  = cout_q;
    assign out_ovf   = ovf_q;
endmodule

// File: tb/tb_digit_serial_adder.sv
// Directed bench for digit_serial_adder: a W=4/D=1 instance and a W=8/D=4 instance.
module tb_digit_serial_adder;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       v0, r0, ci0, sb0, ov0, ordy0, co0, of0;
    logic [3:0] a0, b0, s0;
    logic       v1, r1, ci1, sb1, ov1, ordy1, co1, of1;
    logic [7:0] a1, b1, s1;

    int checks   = 0;
    int failures = 0;

    digit_serial_adder #(.W(4), .D(1)) u0 (
        .clk(clk), .rst(rst),
        .in_valid(v0), .in_ready(r0), .in_a(a0), .in_b(b0), .in_cin(ci0), .in_sub(sb0),
        .out_valid(ov0), .out_ready(ordy0), .out_sum(s0), .out_cout(co0), .out_ovf(of0)
    );

    digit_serial_adder #(.W(8), .D(4)) u1 (
        .clk(clk), .rst(rst),
        .in_valid(v1), .in_ready(r1), .in_a(a1), .in_b(b1), .in_cin(ci1), .in_sub(sb1),
        .out_valid(ov1), .out_ready(ordy1), .out_sum(s1), .out_cout(co1), .out_ovf(of1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full W=4/D=1 transaction: accept, scramble inputs during RUN, wait, check, consume.
    task automatic op0(input string tag, input logic [3:0] a, input logic [3:0] b,
                       input logic ci, input logic sb,
                       input logic [3:0] es, input logic ec, input logic eo);
        int n;
        chk({tag, "_rdy_pre"}, 32'(r0), 1);
        a0 = a; b0 = b; ci0 = ci; sb0 = sb; v0 = 1'b1; ordy0 = 1'b0;
        tick();
        v0 = 1'b0; a0 = ~a; b0 = ~b; ci0 = ~ci; sb0 = ~sb;
        chk({tag, "_rdy_run"}, 32'(r0), 0);
        n = 0;
        while (ov0 !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_latency"}, 32'(n), 4);
        chk({tag, "_sum"}, 32'(s0), 32'(es));
        chk({tag, "_cout"}, 32'(co0), 32'(ec));
        chk({tag, "_ovf"}, 32'(of0), 32'(eo));
        ordy0 = 1'b1;
        tick();
        ordy0 = 1'b0;
        chk({tag, "_vld_post"}, 32'(ov0), 0);
        chk({tag, "_rdy_post"}, 32'(r0), 1);
    endtask

    initial begin
        int seen;
        rst = 1'b1;
        v0 = 1'b1; a0 = 4'h3; b0 = 4'h4; ci0 = 1'b0; sb0 = 1'b0; ordy0 = 1'b0;
        v1 = 1'b1; a1 = 8'h11; b1 = 8'h22; ci1 = 1'b0; sb1 = 1'b0; ordy1 = 1'b0;
        tick();
        tick();
        chk("rst_rdy", 32'(r0), 0);
        chk("rst_vld", 32'(ov0), 0);
        chk("rst_sum", 32'(s0), 0);
        chk("rst_cout", 32'(co0), 0);
        chk("rst_ovf", 32'(of0), 0);
        chk("rst_rdy_u1", 32'(r1), 0);
        rst = 1'b0; v0 = 1'b0; v1 = 1'b0;
        tick();
        chk("rst_rdy_after", 32'(r0), 1);
        chk("rst_vld_after", 32'(ov0), 0);

        op0("add_f_1", 4'hF, 4'h1, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0);
        op0("sub_3_5", 4'h3, 4'h5, 1'b0, 1'b1, 4'hE, 1'b0, 1'b0);
        op0("add_7_1", 4'h7, 4'h1, 1'b0, 1'b0, 4'h8, 1'b0, 1'b1);
        op0("sub_8_1", 4'h8, 4'h1, 1'b0, 1'b1, 4'h7, 1'b1, 1'b1);

        // W=8, D=4: two RUN cycles.
        a1 = 8'hFF; b1 = 8'hFF; ci1 = 1'b1; sb1 = 1'b0; v1 = 1'b1;
        tick();
        v1 = 1'b0;
        chk("w8_vld_t0", 32'(ov1), 0);
        tick();
        chk("w8_vld_t1", 32'(ov1), 0);
        tick();
        chk("w8_vld_t2", 32'(ov1), 1);
        chk("w8_sum", 32'(s1), 'hFF);
        chk("w8_cout", 32'(co1), 1);
        chk("w8_ovf", 32'(of1), 0);
        ordy1 = 1'b1;
        tick();
        ordy1 = 1'b0;
        chk("w8_vld_post", 32'(ov1), 0);
        chk("w8_rdy_post", 32'(r1), 1);

        a1 = 8'h10; b1 = 8'h01; ci1 = 1'b1; sb1 = 1'b1; v1 = 1'b1;
        tick();
        v1 = 1'b0;
        tick();
        tick();
        chk("w8s_vld", 32'(ov1), 1);
        chk("w8s_sum", 32'(s1), 'h0E);
        chk("w8s_cout", 32'(co1), 1);
        chk("w8s_ovf", 32'(of1), 0);
        ordy1 = 1'b1;
        tick();
        ordy1 = 1'b0;

        // Backpressure: 9 + 4 + 1 = 0xE held while the source keeps poking.
        a0 = 4'h9; b0 = 4'h4; ci0 = 1'b1; sb0 = 1'b0; v0 = 1'b1;
        tick();
        v0 = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("bp_vld_enter", 32'(ov0), 1);
        for (int i = 0; i < 5; i++) begin
            v0 = i[0]; a0 = 4'($urandom); b0 = 4'($urandom); sb0 = ~i[0];
            tick();
            chk("bp_sum", 32'(s0), 'hE);
            chk("bp_cout", 32'(co0), 0);
            chk("bp_ovf", 32'(of0), 0);
            chk("bp_vld", 32'(ov0), 1);
            chk("bp_rdy", 32'(r0), 0);
        end
        v0 = 1'b1; ordy0 = 1'b1;
        tick();
        v0 = 1'b0; ordy0 = 1'b0;
        chk("bp_release_vld", 32'(ov0), 0);
        chk("bp_release_rdy", 32'(r0), 1);
        tick();
        chk("bp_no_reaccept", 32'(r0), 1);

        // Reset at T2 of an op abandons it.
        a0 = 4'h5; b0 = 4'h6; ci0 = 1'b0; sb0 = 1'b0; v0 = 1'b1;
        tick();
        v0 = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        chk("abort_vld", 32'(ov0), 0);
        chk("abort_sum", 32'(s0), 0);
        chk("abort_cout", 32'(co0), 0);
        chk("abort_ovf", 32'(of0), 0);
        chk("abort_rdy", 32'(r0), 0);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (ov0 === 1'b1) seen++;
        end
        chk("abort_no_vld", 32'(seen), 0);
        chk("abort_sum_idle", 32'(s0), 0);
        op0("add_2_3", 4'h2, 4'h3, 1'b0, 1'b0, 4'h5, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
